// File: rtl/controlador_sequenciador.sv
// SAP-1 controller-sequencer: six-state one-hot ring (T1..T6) and an opcode
// decoder producing the datapath control word, with a sticky halt.
module controlador_sequenciador #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_JMP = 4'b0011,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       cp,
    output logic       ep,
    output logic       jp,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       hlt
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } state_t;

    state_t state_q, state_d;
    logic   halted_q, halted_d;

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q  <= T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // While clear is low the ring is shown at T1 even before the reset edge.
    assign t_state = clear ? state_q : T1;

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        cp = 1'b0; ep = 1'b0; jp = 1'b0; lm = 1'b0;
        ce = 1'b0; li = 1'b0; ei = 1'b0; la = 1'b0;
        ea = 1'b0; su = 1'b0; eu = 1'b0; lb = 1'b0;
        lo = 1'b0; hlt = 1'b0;

        if (halted_q) begin
            hlt = 1'b1;
        end else begin
            unique case (state_q)
                T1: begin ep = 1'b1; lm = 1'b1; state_d = T2; end
                T2: begin cp = 1'b1; state_d = T3; end
                T3: begin ce = 1'b1; li = 1'b1; state_d = T4; end
                T4: begin
                    state_d = T5;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
                        OP_JMP: begin ei = 1'b1; jp = 1'b1; end
                        OP_OUT: begin ea = 1'b1; lo = 1'b1; end
                        // Ring stays parked at T4 once halted.
                        OP_HLT: begin hlt = 1'b1; halted_d = 1'b1; state_d = T4; end
                        default: ;
                    endcase
                end
                T5: begin
                    state_d = T6;
                    case (opcode)
                        OP_LDA: begin ce = 1'b1; la = 1'b1; end
                        OP_ADD, OP_SUB: begin ce = 1'b1; lb = 1'b1; end
                        default: ;
                    endcase
                end
                T6: begin
                    state_d = T1;
                    case (opcode)
                        OP_ADD: begin eu = 1'b1; la = 1'b1; end
                        OP_SUB: begin eu = 1'b1; la = 1'b1; su = 1'b1; end
                        default: ;
                    endcase
                end
                default: state_d = T1;
            endcase
        end

        if (!clear) begin
            cp = 1'b0; ep = 1'b0; jp = 1'b0; lm = 1'b0;
            ce = 1'b0; li = 1'b0; ei = 1'b0; la = 1'b0;
            ea = 1'b0; su = 1'b0; eu = 1'b0; lb = 1'b0;
            lo = 1'b0; hlt = 1'b0;
        end
    end

endmodule

// File: doc/controlador_sequenciador.md
# controlador_sequenciador

Controller-sequencer for the SAP-1 datapath: a 6-state ring counter (T1..T6) plus instruction decoder that generates the control word for every datapath block. It drives the program counter's increment (`cp`), output (`ep`) and load (`jp`) inputs, and the MAR, RAM, IR, accumulator, ALU, B and output registers. It sits directly upstream of the program counter, consuming the IR opcode nibble.

## Interface
Parameters:
- OP_LDA, 4'b0000, load accumulator from RAM[addr]
- OP_ADD, 4'b0001, A <= A + RAM[addr]
- OP_SUB, 4'b0010, A <= A - RAM[addr]
- OP_JMP, 4'b0011, PC <= addr
- OP_OUT, 4'b1110, output register <= A
- OP_HLT, 4'b1111, stop sequencing

Ports:
- clock  input  1  system clock; all state changes on rising edge
- clear  input  1  reset, synchronous, active-low
- opcode  input  4  IR upper nibble, registered upstream
- t_state  output  6  one-hot ring state, bit0 = T1
- cp  output  1  PC increment enable
- ep  output  1  PC drives bus
- jp  output  1  PC load from bus
- lm  output  1  MAR load
- ce  output  1  RAM drives bus
- li  output  1  IR load
- ei  output  1  IR address nibble drives bus
- la  output  1  accumulator load
- ea  output  1  accumulator drives bus
- su  output  1  ALU subtract select (0 = add)
- eu  output  1  ALU drives bus
- lb  output  1  B register load
- lo  output  1  output register load
- hlt  output  1  halted indicator

## Operation
- All controls active-high, combinational decode of (t_state, opcode, halted register); at most one bus driver (ep, ce, ei, ea, eu) high in any state.
- Fetch, opcode-independent: T1 ep,lm; T2 cp; T3 ce,li.
- Execute T4/T5/T6:
  - LDA: ei,lm / ce,la / none.
  - ADD: ei,lm / ce,lb / eu,la.
  - SUB: ei,lm / ce,lb / eu,la,su.
  - JMP: ei,jp / none / none.
  - OUT: ea,lo / none / none.
  - HLT: hlt / none / none (see halt).
  - Any other opcode: NOP, no controls in T4..T6.
- opcode is decoded only in T4..T6; its value during T1..T3 is ignored.
- Halt: in T4 with OP_HLT, hlt=1 combinationally; on that rising edge the halted register sets, the ring freezes at T4, and all controls except hlt stay 0 indefinitely. Only clear exits halt.
- Fixed 6-cycle instruction; no early return to T1 for short instructions.

## Timing
- Ring advances T1->T2->...->T6->T1, one state per rising edge when not halted.
- Reset: clear=0 sampled at a rising edge sets t_state=6'b000001 and halted=0. While clear=0, all control outputs and hlt are forced to 0 and t_state reads 000001. First fetch controls (ep,lm) appear in the cycle after clear returns high.
- clear=0 mid-instruction, or while halted, aborts unconditionally on the next edge; no partial-instruction state is retained.
- Control outputs are valid within the same cycle as t_state. Datapath loads take effect on the rising edge that ends the state, so PC increments at the end of T2 and jumps at the end of T4.
- t_state is always exactly one-hot; bad states are unreachable, and decoding must not depend on them.

## Test plan
- Reset: hold clear=0 for 2 edges -> t_state=000001, all controls 0, hlt=0. Release -> T1 shows ep=1, lm=1 only.
- Free run with opcode=OP_LDA -> cycle-by-cycle control words T1..T6 as listed above. t_state returns to 000001 after 6 edges; cp=1 only in T2.
- opcode=OP_SUB -> T6 shows eu=1, la=1, su=1. Same run with OP_ADD -> su=0 in every state.
- opcode=OP_JMP -> jp=1 and ei=1 only in T4. With opcode=4'b0101 -> no controls in T4..T6.
- opcode=OP_HLT -> hlt=1 in T4. After the edge: t_state stuck at 001000, hlt=1, all others 0 for 20 cycles. Then clear=0 -> t_state=000001, hlt=0.
- Assert clear=0 during T5 of ADD -> next edge t_state=000001, lb never asserted.
